clock_period_meter: RTL and testbench
=====================================

Name: clock_period_meter

Overview:
- Synthesizable measurement block: the receiving end of a bench clock source.
- Samples an asynchronous test clock `sig_in` and measures its period in cycles of the system clock `clk`.
- Measures a programmable number of consecutive periods and reports the total, minimum and maximum period, or a timeout.
- Used in the TDC design and on-board to check generated clocks against the 100 MHz master clock.

Parameters:
- SYNC_STAGES, 2, synchronizer flip-flops on `sig_in` (legal values 2..4).
- PER_WIDTH, 16, width of the single-period counter and of `min_per`/`max_per`.
- NPER_WIDTH, 8, width of the `nper` request field.
- TIMEOUT_CYCLES, 65535, clk cycles without a detected edge before the measurement aborts (must be ≤ 2^PER_WIDTH-1).

Ports:
- clk  in  1  system/reference clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sig_in  in  1  asynchronous clock under test.
- start  in  1  one-cycle request; sampled only in IDLE.
- nper  in  NPER_WIDTH  number of periods to measure, sampled with `start`; 0 is treated as 1.
- busy  out  1  high from the cycle after an accepted `start` until the cycle `valid` pulses.
- valid  out  1  one-cycle pulse; result outputs are stable from this cycle until the next accepted `start`.
- timeout  out  1  qualifies `valid`: 1 means aborted, no edge seen for TIMEOUT_CYCLES.
- total  out  PER_WIDTH+NPER_WIDTH  sum of measured periods; cannot overflow.
- min_per  out  PER_WIDTH  shortest period measured.
- max_per  out  PER_WIDTH  longest period measured.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, synchronizer chain cleared.
- Reset asserted mid-measurement aborts immediately. No `valid` is issued, and the block is in IDLE after deassertion.
- Synchronizer and edge detect:
  - `sig_in` passes through the SYNC_STAGES flop chain.
  - A rising edge `rise` is flagged when the last stage is 1 and its delayed copy is 0.
  - `rise` is a one-cycle pulse. Edge latency is constant, so measured periods are exact to ±1 clk.
  - `sig_in` high/low times shorter than 1 clk period are not guaranteed to be seen.
- Period definition: number of clk cycles from one `rise` to the next. Example: clk 10 ns, `sig_in` 100 ns → 10.
- FSM states IDLE, ARM, MEASURE, DONE.
- IDLE:
  - `busy`=0.
  - On `start`: latch `nper` (0→1), clear `timeout`, go to ARM.
  - `start` outside IDLE is ignored.
- ARM:
  - Waits for the first `rise`; the inactivity counter runs.
  - On `rise`: load period counter with 1, clear the remaining-period counter to the latched `nper`, set total=0, min=all-ones, max=0, go to MEASURE.
- MEASURE:
  - The period counter increments each cycle without `rise`.
  - On `rise`:
    - p = counter value. Total += p; min = min(min, p); max = max(max, p).
    - Counter reloads to 1 and the remaining count decrements.
    - When the remaining count reaches 0, go to DONE.
- Timeout:
  - In ARM or MEASURE, if TIMEOUT_CYCLES consecutive cycles pass without `rise`, go to DONE with `timeout`=1.
  - On timeout, `total`, `min_per` and `max_per` are forced to 0.
  - The counter never wraps.
- DONE:
  - `valid`=1 for exactly one cycle, `busy` drops in the same cycle, then return to IDLE.
  - `start` in the DONE cycle is ignored; earliest accepted `start` is the following cycle.
- Simultaneous events: `rise` in the same cycle the timeout count is reached → the edge wins, no timeout.
- Result outputs update only at DONE. Intermediate accumulators are internal.
- Latency: `valid` follows the final counted `rise` by 1 clk, plus synchronizer delay relative to `sig_in`.

Test Plan:
- clk 10 ns, `sig_in` 100 ns 50% duty, nper=4, pulse `start` → `valid`=1 once, timeout=0, total=40, min_per=10, max_per=10; `busy` high throughout.
- `sig_in` alternating 80 ns / 120 ns periods, nper=4 → total=40, min_per=8, max_per=12 (±1 on each).
- `sig_in` held at 0, nper=3, TIMEOUT_CYCLES=200 → `valid` with timeout=1 exactly 200 cycles after entering ARM (±1); total=min_per=max_per=0.
- nper=0, `sig_in` 50 ns → behaves as nper=1: total=5, min_per=max_per=5.
- Second `start` pulsed while `busy` → ignored; only one `valid`, with results matching the first request.
- `rst_n` asserted mid-MEASURE → all outputs 0 immediately, no `valid`; after release, a new `start` with nper=2 at 100 ns → total=20.

Source files
------------

// File: rtl/clock_period_meter.sv
// Measures the period of an asynchronous clock sig_in in clk cycles over a
// programmable number of periods, reporting total, min, max or a timeout.
module clock_period_meter #(
    parameter int SYNC_STAGES    = 2,
    parameter int PER_WIDTH      = 16,
    parameter int NPER_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sig_in,
    input  logic                            start,
    input  logic [NPER_WIDTH-1:0]           nper,
    output logic                            busy,
    output logic                            valid,
    output logic                            timeout,
    output logic [PER_WIDTH+NPER_WIDTH-1:0] total,
    output logic [PER_WIDTH-1:0]            min_per,
    output logic [PER_WIDTH-1:0]            max_per
);

    localparam int TOT_WIDTH = PER_WIDTH + NPER_WIDTH;
    localparam logic [PER_WIDTH-1:0] TO_LIMIT = PER_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d;
    logic                   rise;
    logic [PER_WIDTH-1:0]   per_cnt;
    logic [NPER_WIDTH-1:0]  rem_cnt;
    logic [NPER_WIDTH-1:0]  nper_q;
    logic [TOT_WIDTH-1:0]   acc_total;
    logic [PER_WIDTH-1:0]   acc_min;
    logic [PER_WIDTH-1:0]   acc_max;
    logic [TOT_WIDTH-1:0]   sum_nxt;
    logic [PER_WIDTH-1:0]   min_nxt;
    logic [PER_WIDTH-1:0]   max_nxt;
    logic                   expire;
    logic                   last_rise;
    logic                   active;

    function automatic logic [PER_WIDTH-1:0] umin(input logic [PER_WIDTH-1:0] a,
                                                  input logic [PER_WIDTH-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [PER_WIDTH-1:0] umax(input logic [PER_WIDTH-1:0] a,
                                                  input logic [PER_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Synchronizer and rising-edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            sync_d <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sync_d <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;

    // per_cnt doubles as the inactivity counter: it equals the number of
    // consecutive rise-free cycles including the current one.
    assign active    = (state == ARM) || (state == MEASURE);
    assign expire    = !rise && (per_cnt == TO_LIMIT);
    assign last_rise = (state == MEASURE) && rise && (rem_cnt == NPER_WIDTH'(1));
    assign sum_nxt   = acc_total + TOT_WIDTH'(per_cnt);
    assign min_nxt   = umin(acc_min, per_cnt);
    assign max_nxt   = umax(acc_max, per_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     if (rise) state_nxt = MEASURE;
                     else if (expire) state_nxt = DONE;
            MEASURE: if (last_rise || expire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = active;
    assign valid = (state == DONE);

    // Control counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            rem_cnt <= '0;
            nper_q  <= '0;
        end else begin
            if (state == IDLE && start) begin
                nper_q  <= (nper == '0) ? NPER_WIDTH'(1) : nper;
                per_cnt <= PER_WIDTH'(1);
            end else if (active) begin
                if (rise) begin
                    per_cnt <= PER_WIDTH'(1);
                end else if (per_cnt != TO_LIMIT) begin
                    per_cnt <= per_cnt + PER_WIDTH'(1);
                end
            end
            if (state == ARM && rise) begin
                rem_cnt <= nper_q;
            end else if (state == MEASURE && rise) begin
                rem_cnt <= rem_cnt - NPER_WIDTH'(1);
            end
        end
    end

    // Accumulators: data path, only meaningful after the first rise in ARM
    always_ff @(posedge clk) begin
        if (state == ARM && rise) begin
            acc_total <= '0;
            acc_min   <= '1;
            acc_max   <= '0;
        end else if (state == MEASURE && rise) begin
            acc_total <= sum_nxt;
            acc_min   <= min_nxt;
            acc_max   <= max_nxt;
        end
    end

    // Result registers, loaded on the transition into DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout <= 1'b0;
            total   <= '0;
            min_per <= '0;
            max_per <= '0;
        end else begin
            if (state == IDLE && start) begin
                timeout <= 1'b0;
            end else if (last_rise) begin
                timeout <= 1'b0;
                total   <= sum_nxt;
                min_per <= min_nxt;
                max_per <= max_nxt;
            end else if (active && expire) begin
                timeout <= 1'b1;
                total   <= '0;
                min_per <= '0;
                max_per <= '0;
            end
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter: sig_in is generated in whole clk
// periods and expected results are derived from the list of generated periods.
module tb_clock_period_meter;

    localparam int PW = 16;
    localparam int NW = 8;
    localparam int TO = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sig_in = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] nper = '0;
    logic          busy, valid, timeout;
    logic [PW+NW-1:0] total;
    logic [PW-1:0] min_per, max_per;

    clock_period_meter #(
        .SYNC_STAGES(2), .PER_WIDTH(PW), .NPER_WIDTH(NW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .nper(nper),
        .busy(busy), .valid(valid), .timeout(timeout), .total(total),
        .min_per(min_per), .max_per(max_per)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    int accept_cyc = 0;
    bit in_meas = 1'b0;
    int pq[$];

    // model expectations for the current request and the last reported result
    longint exp_total = 0, exp_min = 0, exp_max = 0, exp_to = 0;
    longint last_total = 0, last_min = 0, last_max = 0, last_to = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // compare process
    always begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (valid) begin
                chk("valid_expected", in_meas, 1);
                chk("busy_at_valid", busy, 0);
                chk("timeout", timeout, exp_to);
                chk("total", total, exp_total);
                chk("min_per", min_per, exp_min);
                chk("max_per", max_per, exp_max);
                last_total = exp_total; last_min = exp_min;
                last_max = exp_max; last_to = exp_to;
                in_meas = 1'b0;
                valid_cnt++;
                valid_cyc = cyc;
            end else if (in_meas) begin
                chk("busy_during", busy, 1);
            end else begin
                chk("busy_idle", busy, 0);
                chk("stable_total", total, last_total);
                chk("stable_min", min_per, last_min);
                chk("stable_max", max_per, last_max);
                chk("stable_timeout", timeout, last_to);
            end
        end
    end

    task automatic emit();
        for (int i = 0; i < pq.size(); i++) begin
            sig_in = 1'b1;
            repeat (pq[i] / 2) @(negedge clk);
            sig_in = 1'b0;
            repeat (pq[i] - pq[i] / 2) @(negedge clk);
        end
        if (pq.size() > 0) begin
            sig_in = 1'b1;
            repeat (2) @(negedge clk);
            sig_in = 1'b0;
        end
    endtask

    task automatic set_model(input int nv);
        int n;
        bit to;
        n = (nv == 0) ? 1 : nv;
        to = (pq.size() < n);
        exp_total = 0; exp_min = 0; exp_max = 0;
        if (!to) begin
            exp_min = (1 << PW) - 1;
            for (int i = 0; i < n; i++) begin
                if (pq[i] > TO) to = 1'b1;
                exp_total += pq[i];
                if (pq[i] < exp_min) exp_min = pq[i];
                if (pq[i] > exp_max) exp_max = pq[i];
            end
        end
        if (to) begin
            exp_total = 0; exp_min = 0; exp_max = 0;
        end
        exp_to = to;
    endtask

    task automatic pulse_start(input int nv);
        @(negedge clk);
        start = 1'b1;
        nper = NW'(nv);
        in_meas = 1'b1;
        accept_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic measure(input int nv, input bit poke);
        int v0;
        set_model(nv);
        v0 = valid_cnt;
        pulse_start(nv);
        repeat (2) @(negedge clk);
        fork
            emit();
            begin
                if (poke) begin
                    repeat (6) @(negedge clk);
                    start = 1'b1;
                    nper = NW'(7);
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        join
        for (int k = 0; k < 1000 && valid_cnt == v0; k++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("valid_count", valid_cnt - v0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_total", total, 0);
        chk("rst_min", min_per, 0);
        chk("rst_max", max_per, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 100 ns period, nper=4
        pq = '{10, 10, 10, 10};
        measure(4, 1'b0);
        chk("t1_total", total, 40);
        chk("t1_min", min_per, 10);
        chk("t1_max", max_per, 10);
        chk("t1_to", timeout, 0);

        // alternating 80/120 ns
        pq = '{8, 12, 8, 12};
        measure(4, 1'b0);
        chk("t2_total", total, 40);
        chk("t2_min", min_per, 8);
        chk("t2_max", max_per, 12);

        // no edges: timeout from ARM
        pq = '{};
        measure(3, 1'b0);
        chk("t3_to", timeout, 1);
        chk("t3_total", total, 0);
        chk("t3_min", min_per, 0);
        chk("t3_max", max_per, 0);
        checks++;
        if (valid_cyc - accept_cyc < TO - 1 || valid_cyc - accept_cyc > TO + 1) begin
            errors++;
            $display("FAIL t3_latency: got %0d cycles expected %0d", valid_cyc - accept_cyc, TO);
        end

        // nper=0 acts as 1, 50 ns period
        pq = '{5};
        measure(0, 1'b0);
        chk("t4_total", total, 5);
        chk("t4_min", min_per, 5);
        chk("t4_max", max_per, 5);

        // second start while busy is ignored
        pq = '{10, 10, 10};
        measure(2, 1'b1);
        chk("t5_total", total, 20);
        chk("t5_max", max_per, 10);

        // period exactly equal to the timeout: edge wins
        pq = '{TO};
        measure(1, 1'b0);
        chk("t6_to", timeout, 0);
        chk("t6_total", total, 200);
        chk("t6_min", min_per, 200);

        // timeout while in MEASURE
        pq = '{12};
        measure(2, 1'b0);
        chk("t7_to", timeout, 1);
        chk("t7_total", total, 0);

        // reset in the middle of a measurement
        pq = '{10};
        measure(1, 1'b0);
        chk("t8_pre_total", total, 10);
        begin
            int v0;
            v0 = valid_cnt;
            pq = '{10, 10};
            pulse_start(4);
            repeat (2) @(negedge clk);
            emit();
            rst_n = 1'b0;
            sig_in = 1'b0;
            in_meas = 1'b0;
            last_total = 0; last_min = 0; last_max = 0; last_to = 0;
            #1;
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_valid", valid, 0);
            chk("mid_rst_total", total, 0);
            chk("mid_rst_min", min_per, 0);
            chk("mid_rst_max", max_per, 0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (20) @(negedge clk);
            chk("mid_rst_no_valid", valid_cnt - v0, 0);
        end
        pq = '{10, 10};
        measure(2, 1'b0);
        chk("t9_total", total, 20);
        chk("t9_to", timeout, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
